sample_framer: RTL
==================

SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: sample, header and checksum width in bits.
REQ-002 Parameter FRAME_LEN, default 16: samples per frame; legal range 2..256.
REQ-003 Parameter HEADER, default 8'hA5: first byte of every frame.
REQ-004 clk_i  input  1  read-domain clock; the design is single-clock.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 enable_i  input  1  permits the start of a new frame.
REQ-007 fifo_empty_i  input  1  FIFO read-side empty flag, registered in the clk_i domain.
REQ-008 fifo_data_i  input  DATA_WIDTH  FIFO memory data at the current read address; valid whenever fifo_empty_i is low.
REQ-009 fifo_inc_o  output  1  combinational pop strobe to the read-pointer increment input.
REQ-010 tx_data_o  output  DATA_WIDTH  registered stream data.
REQ-011 tx_valid_o  output  1  registered stream valid.
REQ-012 tx_ready_i  input  1  downstream ready.
REQ-013 frame_done_o  output  1  registered one-cycle pulse after the checksum byte is accepted.

Function
REQ-014 The block SHALL emit frames as HEADER, then FRAME_LEN FIFO samples in pop order, then CHECKSUM, where CHECKSUM = sum of the FRAME_LEN samples mod 2^DATA_WIDTH (header excluded).
REQ-015 A transfer SHALL occur on a rising edge with tx_valid_o=1 and tx_ready_i=1.
REQ-016 While tx_valid_o=1 and tx_ready_i=0, tx_data_o and tx_valid_o SHALL hold stable.
REQ-017 The output register is "free" when tx_valid_o=0 or tx_ready_i=1; sustained throughput SHALL be one byte per cycle.
REQ-018 FSM states SHALL be IDLE, SAMPLE, CSUM, LAST.
REQ-019 IDLE: when enable_i=1 and fifo_empty_i=0, load HEADER, set tx_valid_o, clear count and sum, go to SAMPLE. The header is therefore valid 1 cycle after the condition.
REQ-020 SAMPLE, when free and fifo_empty_i=0: load fifo_data_i, set tx_valid_o, assert fifo_inc_o in that same cycle, add the sample to sum, and increment count; after the FRAME_LEN-th sample, go to CSUM.
REQ-021 SAMPLE, when free and fifo_empty_i=1: clear tx_valid_o (bubble), do not pop, and remain in SAMPLE.
REQ-022 CSUM, when free: load sum, set tx_valid_o, go to LAST.
REQ-023 LAST: on transfer, clear tx_valid_o, pulse frame_done_o for 1 cycle, and go to IDLE; the next header appears no earlier than the following cycle.
REQ-024 fifo_inc_o SHALL never be asserted when fifo_empty_i=1 or outside SAMPLE; it SHALL assert exactly FRAME_LEN times per frame.
REQ-025 Deasserting enable_i mid-frame SHALL NOT abort the frame; it only blocks the next IDLE start.
REQ-026 Sample count width SHALL be $clog2(FRAME_LEN+1) bits; the sum register is DATA_WIDTH bits and wraps silently.

Reset
REQ-027 When rst_i=0, asynchronously: state=IDLE, tx_valid_o=0, tx_data_o=0, frame_done_o=0, count=0, sum=0; fifo_inc_o=0 combinationally.
REQ-028 Reset mid-frame SHALL abandon the partial frame. Samples already popped are lost and the FIFO is not rewound; the first frame after reset starts with HEADER.

Verification
REQ-029 FRAME_LEN=4; FIFO holds 01,02,03,04; tx_ready_i=1 -> stream A5,01,02,03,04,0A on consecutive cycles, fifo_inc_o pulses 4 times, and frame_done_o pulses once.
REQ-030 Wrap: samples FF,FF,FF,FF -> checksum FC.
REQ-031 Backpressure: tx_ready_i=0 for 3 cycles while sample 02 is presented -> tx_data_o stays 02 with tx_valid_o=1, no fifo_inc_o during the stall, and no byte is lost or duplicated.
REQ-032 FIFO empties after sample 02 for 5 cycles -> tx_valid_o=0 during the gap, no pop, and the frame resumes with 03 and correct checksum 0A.
REQ-033 enable_i=0 with a non-empty FIFO -> no output and no pops. Dropping enable_i after the header -> the frame completes and no second header follows.
REQ-034 rst_i low after 2 samples of a frame -> all outputs 0 immediately. After release, the next frame starts with A5 and its checksum covers only the new samples.

Source files
------------

// File: rtl/sample_framer_if.sv
// Byte-stream framer bus: FIFO read side plus ready/valid output stream.
interface sample_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_inc_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic                  frame_done_o;

    // Framer side
    modport slave (
        input  fifo_empty_i, fifo_data_i, tx_ready_i,
        output fifo_inc_o, tx_data_o, tx_valid_o, frame_done_o
    );

    // FIFO / sink side
    modport master (
        output fifo_empty_i, fifo_data_i, tx_ready_i,
        input  fifo_inc_o, tx_data_o, tx_valid_o, frame_done_o
    );
endinterface

// File: rtl/sample_framer.sv
// Pulls FRAME_LEN samples from a FIFO and emits HEADER, samples, checksum
// on a ready/valid byte stream with a single output register.
module sample_framer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FRAME_LEN  = 16,
    parameter logic [DATA_WIDTH-1:0] HEADER     = 'hA5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    sample_framer_if.slave   bus
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CSUM, LAST} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  fifo_inc;

    logic free;
    logic start;
    logic pop;
    logic xfer;

    // Output register can take a new byte when empty or being drained this cycle.
    assign free  = !tx_valid_q || bus.tx_ready_i;
    assign start = enable_i && !bus.fifo_empty_i;
    assign pop   = (state_q == SAMPLE) && free && !bus.fifo_empty_i;
    assign xfer  = tx_valid_q && bus.tx_ready_i;

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= '0;
            sum_q        <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SAMPLE;
            SAMPLE:  if (pop && (count_q == LAST_CNT)) state_d = CSUM;
            CSUM:    if (free) state_d = LAST;
            LAST:    if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register loads, running sum/count and the FIFO pop strobe.
    always_comb begin
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        count_d      = count_q;
        sum_d        = sum_q;
        fifo_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_data_d  = HEADER;
                    tx_valid_d = 1'b1;
                    count_d    = '0;
                    sum_d      = '0;
                end
            end
            SAMPLE: begin
                if (free) begin
                    if (!bus.fifo_empty_i) begin
                        tx_data_d  = bus.fifo_data_i;
                        tx_valid_d = 1'b1;
                        fifo_inc   = 1'b1;
                        sum_d      = sum_q + bus.fifo_data_i;
                        count_d    = count_q + 1'b1;
                    end else begin
                        // Starved: drop valid rather than re-send the last byte.
                        tx_valid_d = 1'b0;
                    end
                end
            end
            CSUM: begin
                if (free) begin
                    tx_data_d  = sum_q;
                    tx_valid_d = 1'b1;
                end
            end
            LAST: begin
                if (xfer) begin
                    tx_valid_d   = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.fifo_inc_o   = fifo_inc;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.frame_done_o = frame_done_q;

endmodule
